// File: rtl/aes_pkg.sv
// Shared AES definitions: block/round constants, controller state encoding
// and the GF(2^8) byte helpers used by the round datapath.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES256_NR = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Multiply by x (0x02) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] mb2(input logic [7:0] x);
    return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] mb3(input logic [7:0] x);
    return mb2(x) ^ x;
  endfunction

  // Shift-and-add field multiply; b is consumed LSB first.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] bb;
    p  = 8'h00;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = mb2(x);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as SubBytes requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  // S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // MixColumns on one column, row 0 in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {mb2(a0) ^ mb3(a1) ^ a2 ^ a3,
            a0 ^ mb2(a1) ^ mb3(a2) ^ a3,
            a0 ^ a1 ^ mb2(a2) ^ mb3(a3),
            mb3(a0) ^ a1 ^ a2 ^ mb2(a3)};
  endfunction

endpackage

// File: rtl/aes256_round_ctrl_if.sv
// Handshake and key-store bus of the AES-256 round controller.
//   in_valid/in_ready/in_block   : plaintext input handshake
//   rk_idx/rk                    : round-key request and same-cycle key return
//   out_valid/out_ready/out_block: ciphertext output handshake
//   busy                         : block in flight
// slave = controller side, master = environment side.
interface aes256_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int unsigned RND_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_block;
  logic [RND_W-1:0]     rk_idx;
  logic [AES_BLK_W-1:0] rk;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_block;
  logic                 busy;

  modport slave (
    input  in_valid, in_block, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_block, busy
  );

  modport master (
    output in_valid, in_block, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_round.sv
// One combinational AES cipher round:
// SubBytes -> ShiftRows -> MixColumns (skipped when final_rnd) -> AddRoundKey.
//   state_in    : current state, byte 0 in [127:120], bytes column-major
//   rk          : round key
//   final_rnd   : bypass MixColumns
//   state_nxt_c : next state
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 final_rnd,
  output logic [AES_BLK_W-1:0] state_nxt_c
);

  // Indexed by AES byte number (4*column + row), not by bit position.
  logic [15:0][7:0] sb;
  logic [15:0][7:0] sr;
  logic [15:0][7:0] mc;

  for (genvar b = 0; b < 16; b++) begin : g_sub
    assign sb[b] = sbox(state_in[127-8*b -: 8]);
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
      mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
  end

  for (genvar b = 0; b < 16; b++) begin : g_ark
    assign state_nxt_c[127-8*b -: 8] = (final_rnd ? sr[b] : mc[b]) ^ rk[127-8*b -: 8];
  end

endmodule

// File: rtl/aes256_round_ctrl.sv
// Iterative AES-256 encryption controller: initial AddRoundKey on accept,
// then one cipher round per clock; round keys fetched by index from an
// external key-schedule store.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake / key-store interface (slave side)
module aes256_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR    = AES256_NR,
  parameter int unsigned RND_W = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  aes256_round_ctrl_if.slave bus
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

  aes_fsm_e             fsm_q, fsm_d;
  logic [RND_W-1:0]     rnd_q, rnd_d;
  logic [AES_BLK_W-1:0] state_q, state_d;
  logic [AES_BLK_W-1:0] round_c;
  logic                 last_rnd_c;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic [RND_W-1:0]     rk_idx_q, rk_idx_d;

  assign last_rnd_c = (rnd_q == LAST_RND);

  aes_round u_round (
    .state_in    (state_q),
    .rk          (bus.rk),
    .final_rnd   (last_rnd_c),
    .state_nxt_c (round_c)
  );

  // Next state, counter, datapath and the registered output values.
  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = bus.in_block ^ bus.rk;
          rnd_d   = RND_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_c;
        if (last_rnd_c) fsm_d = DONE;
        else            rnd_d = rnd_q + RND_W'(1);
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
    // Outputs are registered, so they are decoded from the next state.
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
    rk_idx_d    = (fsm_d == ROUND) ? rnd_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= '0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.out_block = state_q;

endmodule

// File: tb/tb_aes256_round_ctrl.sv
// Scoreboard bench for aes256_round_ctrl with an FIPS-197-level AES-256 model.
module tb_aes256_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes256_round_ctrl_if #(.RND_W(4)) bus ();

  aes256_round_ctrl #(.NR(14), .RND_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_at  = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_tab [15];
  logic [255:0] cur_key;
  logic [127:0] exp_q [$];
  int           rk_log [$];

  // Key-schedule store: combinational lookup by requested index.
  assign bus.rk = (bus.rk_idx <= 4'd14) ? rk_tab[bus.rk_idx] : '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 8'h01) != 8'h00) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 15'h0001) != 15'h0000) p = p ^ (15'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    return 8'(v >> (120 - 8 * i));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Round key r of the AES-256 key expansion (Nk=8).
  function automatic logic [127:0] m_rk(input logic [255:0] key, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = 32'(key >> (224 - 32 * i));
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [255:0] key);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   v;
    logic [127:0] k;
    logic [127:0] res;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    k = m_rk(key, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = byte_of(pt, 4*c+r) ^ byte_of(k, 4*c+r);
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 14) begin
            v = 8'h00;
            for (int kk = 0; kk < 4; kk++) v = v ^ m_mul(coef[(kk-r+4)%4], t[kk][c]);
            s[r][c] = v;
          end else begin
            s[r][c] = t[r][c];
          end
        end
      k = m_rk(key, rnd);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ byte_of(k, 4*c+r);
    end
    res = '0;
    for (int i = 0; i < 16; i++) res = {res[119:0], s[i%4][i/4]};
    return res;
  endfunction

  task automatic load_key(input logic [255:0] key);
    cur_key = key;
    for (int r = 0; r < 15; r++) rk_tab[r] = m_rk(key, r);
  endtask

  // ---------------- input monitor: push expectations, log rk_idx ----------------
  logic prev_ov_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rk_log.delete();
      prev_ov_a = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(m_encrypt(bus.in_block, cur_key));
        hs_at = cyc + 1;
        rk_log.delete();
        rk_log.push_back(int'(bus.rk_idx));
      end else if (bus.busy && !bus.out_valid) begin
        rk_log.push_back(int'(bus.rk_idx));
      end else if (bus.out_valid && !prev_ov_a) begin
        chk("rk_seq_len", 128'(rk_log.size()), 128'(15));
        for (int i = 0; i < 15; i++)
          chk("rk_seq", (i < rk_log.size()) ? 128'(rk_log[i]) : 'x, 128'(i));
      end
      prev_ov_a = bus.out_valid;
    end
  end

  // ---------------- output monitor: pop and compare ----------------
  logic prev_ov_b = 1'b0;
  logic [127:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov_b = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov_b) chk("latency", 128'(cyc - hs_at), 128'(14));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_output: got %h with no block pending", bus.out_block);
        end else begin
          exp_v = exp_q.pop_front();
          chk("ciphertext", bus.out_block, exp_v);
        end
      end
      prev_ov_b = bus.out_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] pt);
    logic ok;
    ok = 1'b0;
    bus.in_block = pt;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("send");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin got = 1'b1; break; end
    end
    if (!got) tmo("wait_out");
  endtask

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ZERO_CT  = 128'hdc95c078a2408989ad48a21492842087;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         got;
    logic         ok;
    logic [7:0]   inv;
    logic [127:0] snap;
    logic [255:0] rkey;
    logic [127:0] rpt;

    // S-box by exhaustive inverse search plus affine transform.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int r = 0; r < 15; r++) rk_tab[r] = '0;
    cur_key       = '0;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy",      128'(bus.busy),      128'(0));
    chk("rst_rk_idx",    128'(bus.rk_idx),    128'(0));
    chk("rst_out_block", bus.out_block,       128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.3 vector.
    load_key(FIPS_KEY);
    send(FIPS_PT);
    wait_out(got);
    if (got) chk("fips_ct", bus.out_block, FIPS_CT);
    @(posedge clk); #1;

    // All-zero vector.
    load_key('0);
    send('0);
    wait_out(got);
    if (got) chk("zero_ct", bus.out_block, ZERO_CT);
    @(posedge clk); #1;

    // Backpressure in DONE with a competing in_valid.
    load_key(FIPS_KEY);
    bus.out_ready = 1'b0;
    send(128'hdeadbeef_01234567_89abcdef_cafef00d);
    wait_out(got);
    snap = bus.out_block;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_out_block", bus.out_block, snap);
      chk("bp_in_ready",  128'(bus.in_ready), 128'(0));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // Back-to-back blocks with in_valid held high.
    bus.in_block = FIPS_PT;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("b2b_first_accept");
    @(posedge clk); #1;
    bus.in_block = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    wait_out(got);
    if (got) chk("b2b_first_ct", bus.out_block, FIPS_CT);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(got);
    @(posedge clk); #1;

    // Reset in the middle of a block.
    load_key(FIPS_KEY);
    send(FIPS_PT);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rk_idx == 4'd7) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("mid_round7");
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    rk_log.delete();
    chk("mid_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_in_ready",  128'(bus.in_ready),  128'(1));
    chk("mid_busy",      128'(bus.busy),      128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_out_block", bus.out_block,       128'(0));
    chk("rel_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rel_rk_idx",    128'(bus.rk_idx),    128'(0));
    @(posedge clk); #1;
    send(FIPS_PT);
    wait_out(got);
    if (got) chk("post_rst_ct", bus.out_block, FIPS_CT);
    @(posedge clk); #1;

    // Random keys and plaintexts with random output backpressure.
    for (int n = 0; n < 6; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(rkey);
      send(rpt);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) tmo("rand_out");
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
